// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the HEX display fetch master:
//   - state_t       : fetch FSM states
//   - fetch_dbg_t   : snapshot of FSM-internal state, kept as one named signal
//   - SEG7_BLANK    : all segments off (active-low)
//   - SEG7_TABLE    : nibble -> {g,f,e,d,c,b,a} active-low segment patterns
package seg7_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_DIG  = 3'd1,
        ST_WT_DIG  = 3'd2,
        ST_RD_MSK  = 3'd3,
        ST_WT_MSK  = 3'd4,
        ST_WR_STAT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    typedef struct packed {
        state_t     state;
        logic       pending;
        logic [1:0] lat_cnt;
    } fetch_dbg_t;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    // Index 15 is leftmost: F E D C B A 9 8 7 6 5 4 3 2 1 0
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder
//   Combinational nibble to seven-segment decoder with blanking.
//   Ports:
//     nibble  in  4  hex digit value
//     blank   in  1  1 = all segments off
//     seg     out 7  {g,f,e,d,c,b,a}, active-low
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG7_BLANK : SEG7_TABLE[nibble];

endmodule

// File: rtl/seg7_avalon_fetch_master.sv
// seg7_avalon_fetch_master
//   Avalon-MM master that periodically reads a digit word and a blank-mask
//   word from on-chip RAM, optionally writes a pass counter back as a status
//   word, and drives six active-low HEX digits from the fetched data.
//   Ports:
//     clk, reset         clock, asynchronous active-high reset
//     enable             1 = refresh passes run
//     avm_*              Avalon-MM master port (word addressed, 32-bit)
//     busy               1 while a pass is in progress
//     pass_done          one-cycle pulse in the final cycle of a pass
//     hex0..hex5         registered segment outputs {g,f,e,d,c,b,a}, active-low
//
//   Transfer handshake: avm_chipselect is the request (valid) and is held,
//   together with avm_address/avm_write/avm_writedata, until a cycle in which
//   avm_waitrequest=0 (ready). That cycle is the one accepted transfer; the
//   FSM leaves the request state on the following edge so a request is never
//   repeated. Read data is taken exactly READ_LATENCY cycles after acceptance.
module seg7_avalon_fetch_master
    import seg7_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int BASE_ADDR      = 0,
    parameter int REFRESH_CYCLES = 50000,
    parameter int READ_LATENCY   = 1,
    parameter int STATUS_EN      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              pass_done,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
);

    localparam int RC_W = $clog2(REFRESH_CYCLES);
    localparam logic [RC_W-1:0]   REFRESH_LAST = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [1:0]        LAT_LAST     = 2'(READ_LATENCY - 1);
    // Address sums are truncated so the three words wrap at the top of memory.
    localparam logic [ADDR_W-1:0] ADDR_DIG     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MSK     = ADDR_W'(BASE_ADDR + 1);
    localparam logic [ADDR_W-1:0] ADDR_STAT    = ADDR_W'(BASE_ADDR + 2);

    state_t          state, next_state;
    logic [RC_W-1:0] refresh_cnt;
    logic            pending;
    logic [1:0]      lat_cnt;
    logic [23:0]     dig_shadow;
    logic [5:0]      msk_shadow;
    logic [31:0]     pass_cnt;
    logic [5:0][6:0] hex_q;
    logic [5:0][6:0] seg_dec;

    logic tick;
    logic start;
    logic lat_done;
    logic in_wait;

    fetch_dbg_t fsm_dbg;
    logic       unused_bits;

    assign tick     = enable && (refresh_cnt == REFRESH_LAST);
    assign start    = (state == ST_IDLE) && enable && (tick || pending);
    assign in_wait  = (state == ST_WT_DIG) || (state == ST_WT_MSK);
    assign lat_done = (lat_cnt == LAT_LAST);

    assign busy           = (state != ST_IDLE);
    assign avm_byteenable = 4'hF;

    assign fsm_dbg     = '{state: state, pending: pending, lat_cnt: lat_cnt};
    assign unused_bits = ^{avm_readdata[31:24], fsm_dbg};

    // Refresh timer and the one-deep request queue for ticks that land mid-pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            pending     <= 1'b0;
        end else begin
            if (!enable || refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            if (start) begin
                pending <= 1'b0;
            end else if (tick && busy) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latency counter restarts on every entry to a wait state; lat_done marks
    // the cycle in which avm_readdata belongs to the accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt <= '0;
        end else if (in_wait && !lat_done) begin
            lat_cnt <= lat_cnt + 1'b1;
        end else begin
            lat_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_shadow <= '0;
            msk_shadow <= '0;
            pass_cnt   <= '0;
            hex_q      <= {6{SEG7_BLANK}};
        end else begin
            if (state == ST_WT_DIG && lat_done) begin
                dig_shadow <= avm_readdata[23:0];
            end
            if (state == ST_WT_MSK && lat_done) begin
                msk_shadow <= avm_readdata[5:0];
            end
            // All six digits move together so software never sees a torn update.
            if (state == ST_DONE) begin
                pass_cnt <= pass_cnt + 32'd1;
                hex_q    <= seg_dec;
            end
        end
    end

    always_comb begin
        next_state     = state;
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        pass_done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RD_DIG;
                end
            end
            ST_RD_DIG: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_DIG;
                if (!avm_waitrequest) begin
                    next_state = ST_WT_DIG;
                end
            end
            ST_WT_DIG: begin
                if (lat_done) begin
                    next_state = ST_RD_MSK;
                end
            end
            ST_RD_MSK: begin
                avm_chipselect = 1'b1;
                avm_address    = ADDR_MSK;
                if (!avm_waitrequest) begin
                    next_state = ST_WT_MSK;
                end
            end
            ST_WT_MSK: begin
                if (lat_done) begin
                    next_state = (STATUS_EN != 0) ? ST_WR_STAT : ST_DONE;
                end
            end
            ST_WR_STAT: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = ADDR_STAT;
                avm_writedata  = pass_cnt + 32'd1;
                if (!avm_waitrequest) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                pass_done  = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < 6; i++) begin : g_dec
        seg7_hex_decoder u_dec (
            .nibble (dig_shadow[4*i +: 4]),
            .blank  (msk_shadow[i]),
            .seg    (seg_dec[i])
        );
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_seg7_avalon_fetch_master.sv
module tb_seg7_avalon_fetch_master;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (REFRESH_CYCLES=16) ----------------
    logic        enable = 1'b0;
    logic [11:0] avm_address;
    logic        avm_chipselect, avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_waitrequest = 1'b0;
    logic        busy, pass_done;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  hx [6];

    assign hx[0] = hex0;
    assign hx[1] = hex1;
    assign hx[2] = hex2;
    assign hx[3] = hex3;
    assign hx[4] = hex4;
    assign hx[5] = hex5;

    seg7_avalon_fetch_master #(
        .ADDR_W(12), .BASE_ADDR(0), .REFRESH_CYCLES(16), .READ_LATENCY(1), .STATUS_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .pass_done(pass_done),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    // ---------------- second DUT (REFRESH_CYCLES=8) for queued-tick test ----------------
    logic        enable8 = 1'b0;
    logic [11:0] addr8;
    logic        cs8, wr8;
    logic [3:0]  be8;
    logic [31:0] wdata8;
    logic [31:0] rdata8 = 32'd0;
    logic        wait8 = 1'b0;
    logic        busy8, pd8;
    logic [6:0]  h8_0, h8_1, h8_2, h8_3, h8_4, h8_5;

    seg7_avalon_fetch_master #(
        .ADDR_W(12), .BASE_ADDR(0), .REFRESH_CYCLES(8), .READ_LATENCY(1), .STATUS_EN(1)
    ) dut8 (
        .clk(clk), .reset(reset), .enable(enable8),
        .avm_address(addr8), .avm_chipselect(cs8), .avm_write(wr8),
        .avm_byteenable(be8), .avm_writedata(wdata8),
        .avm_readdata(rdata8), .avm_waitrequest(wait8),
        .busy(busy8), .pass_done(pd8),
        .hex0(h8_0), .hex1(h8_1), .hex2(h8_2), .hex3(h8_3), .hex4(h8_4), .hex5(h8_5)
    );

    // ---------------- behavioural RAM (read latency 1) ----------------
    logic [31:0] ram_dig = 32'd0;
    logic [31:0] ram_msk = 32'd0;
    logic [31:0] ram_stat = 32'd0;

    always @(posedge clk) begin
        if (avm_chipselect && !avm_waitrequest) begin
            if (avm_write) begin
                if (avm_address == 12'd2) ram_stat <= avm_writedata;
            end else begin
                case (avm_address)
                    12'd0:   avm_readdata <= ram_dig;
                    12'd1:   avm_readdata <= ram_msk;
                    default: avm_readdata <= 32'hDEAD_BEEF;
                endcase
            end
        end
    end

    // ---------------- waitrequest drivers and bus monitors ----------------
    int          stall_left = 0;
    logic [11:0] stall_addr = 12'd1;
    int          msk_cs_cycles = 0;
    int          msk_accepts = 0;
    int          total_cs = 0;

    always @(negedge clk) begin
        if (avm_chipselect && avm_address == stall_addr && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else begin
            avm_waitrequest = 1'b0;
        end
        if (avm_chipselect) begin
            total_cs++;
            if (!avm_write && avm_address == 12'd1) begin
                msk_cs_cycles++;
                if (!avm_waitrequest) msk_accepts++;
            end
        end
    end

    int stall8_left = 0;
    int starts8 = 0;
    int done8 = 0;

    always @(negedge clk) begin
        if (cs8 && stall8_left > 0) begin
            wait8 = 1'b1;
            stall8_left--;
        end else begin
            wait8 = 1'b0;
        end
        if (cs8 && !wr8 && addr8 == 12'd0 && !wait8) starts8++;
        if (pd8) done8++;
    end

    // ---------------- scoreboard ----------------
    int vec_cnt = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_pass(input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (pass_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [31:0]     dig;
        logic [31:0]     msk;
        logic [5:0][6:0] hex;   // hex[0] is hex0
        logic [31:0]     stat;
    } vec_t;

    vec_t vecs [4];

    initial begin
        bit ok;
        int cs_before;

        vecs[0] = '{32'h0054_3210, 32'h0000_0000,
                    {7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 32'd1};
        vecs[1] = '{32'h0054_3210, 32'h0000_0021,
                    {7'h7F, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F}, 32'd2};
        vecs[2] = '{32'h00FE_DCBA, 32'h0000_0000,
                    {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}, 32'd3};
        vecs[3] = '{32'hFF98_7654, 32'hFFFF_FFCA,
                    {7'h10, 7'h00, 7'h7F, 7'h02, 7'h7F, 7'h19}, 32'd4};

        // ---- reset values ----
        ram_dig = vecs[0].dig;
        ram_msk = vecs[0].msk;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_wdata", avm_writedata, 32'd0);
        chk("rst_be", 32'(avm_byteenable), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pass_done", 32'(pass_done), 32'd0);
        for (int k = 0; k < 6; k++) chk($sformatf("rst_hex%0d", k), 32'(hx[k]), 32'h7F);

        // ---- reset asserted mid-WT_DIG ----
        reset  = 1'b0;
        enable = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write && avm_address == 12'd0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("first_rd_dig_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
        chk("wt_dig_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_cs", 32'(avm_chipselect), 32'd0);
        chk("midrst_write", 32'(avm_write), 32'd0);
        chk("midrst_addr", 32'(avm_address), 32'd0);
        chk("midrst_wdata", avm_writedata, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pass_done", 32'(pass_done), 32'd0);
        chk("midrst_hex0", 32'(hex0), 32'h7F);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (avm_chipselect) begin
                ok = 1'b1;
                break;
            end
        end
        chk("restart_seen", 32'(ok), 32'd1);
        chk("restart_addr", 32'(avm_address), 32'd0);
        chk("restart_is_read", 32'(avm_write), 32'd0);

        // ---- table-driven passes ----
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                ram_dig = vecs[i].dig;
                ram_msk = vecs[i].msk;
            end
            wait_pass(60, ok);
            chk($sformatf("v%0d_pass_seen", i), 32'(ok), 32'd1);
            @(negedge clk);
            for (int k = 0; k < 6; k++)
                chk($sformatf("v%0d_hex%0d", i, k), 32'(hx[k]), 32'(vecs[i].hex[k]));
            chk($sformatf("v%0d_status", i), ram_stat, vecs[i].stat);
            chk($sformatf("v%0d_pulse_width", i), 32'(pass_done), 32'd0);
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        end

        // ---- waitrequest stall of 3 cycles on RD_MSK ----
        ram_msk       = 32'd0;
        stall_addr    = 12'd1;
        stall_left    = 3;
        msk_cs_cycles = 0;
        msk_accepts   = 0;
        wait_pass(80, ok);
        chk("stall_pass_seen", 32'(ok), 32'd1);
        #1;
        chk("stall_msk_cs_cycles", 32'(msk_cs_cycles), 32'd4);
        chk("stall_msk_accepts", 32'(msk_accepts), 32'd1);
        @(negedge clk);
        chk("stall_hex1", 32'(hex1), 32'h12);
        chk("stall_hex3", 32'(hex3), 32'h78);
        chk("stall_status", ram_stat, 32'd5);

        // ---- enable dropped during RD_MSK ----
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write && avm_address == 12'd1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("dis_rd_msk_seen", 32'(ok), 32'd1);
        enable = 1'b0;
        wait_pass(40, ok);
        chk("dis_pass_completes", 32'(ok), 32'd1);
        @(negedge clk);
        chk("dis_status", ram_stat, 32'd6);
        chk("dis_busy_falls", 32'(busy), 32'd0);
        #1;
        cs_before = total_cs;
        repeat (40) @(negedge clk);
        #1;
        chk("dis_no_more_cs", 32'(total_cs), 32'(cs_before));
        chk("dis_still_idle", 32'(busy), 32'd0);

        // ---- REFRESH_CYCLES=8, long stall: exactly one queued pass ----
        stall8_left = 20;
        starts8     = 0;
        done8       = 0;
        enable8     = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (done8 == 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("q_first_pass_done", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("q_second_starts_at_once", 32'(starts8), 32'd2);
        enable8 = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        chk("q_pass_count", 32'(done8), 32'd2);
        chk("q_start_count", 32'(starts8), 32'd2);
        chk("q_idle", 32'(busy8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
